wide_add_seq: RTL and testbench
===============================

// Module: wide_add_seq
// PURPOSE
//  Sequencer that computes wide (8*NBYTES-bit) unsigned sums using one 8-bit add per cycle.
//  Operands are latched on a start pulse. Bytes are processed LSB first, with carry chained
//  through a registered carry flag. Final sum and carry-out are held until the next start.
//  Sits between a command source and consumers needing multi-byte sums with minimal adder area.
// PARAMETERS
//  NBYTES  4  number of 8-bit bytes per operand (>=1); operand/sum width W = 8*NBYTES
// PORTS
//  clk     in   1   system clock, rising edge
//  rst_n   in   1   asynchronous, active-low reset
//  start   in   1   request; accepted only when busy==0
//  a       in   W   operand A, sampled on the accepting edge only
//  b       in   W   operand B, sampled on the accepting edge only
//  busy    out  1   1 while bytes are being added
//  done    out  1   one-cycle pulse: sum/cout valid
//  sum     out  W   result, low W bits of a+b
//  cout    out  1   carry out of the MSB byte (a+b > 2^W-1)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0; done=0; sum=0; cout=0; byte index=0; carry=0
//   - Latched operands cleared to 0.
//  States: IDLE, ADD, DONE. All outputs are registered.
//  IDLE:
//   - start=1 -> latch a/b; sum<=0; cout<=0; carry<=0; idx<=0; busy<=1; go to ADD.
//   - start=0 -> stay in IDLE.
//  ADD (one byte per cycle):
//   - s9 = {1'b0,A[idx]} + {1'b0,B[idx]} + carry   (9-bit add)
//   - sum byte[idx] <= s9[7:0]; carry <= s9[8]; idx <= idx+1
//   - On byte NBYTES-1: cout <= s9[8]; busy<=0; done<=1; go to DONE.
//   - start is ignored throughout ADD; operands are never re-sampled mid-operation.
//  DONE (one cycle, done=1):
//   - start=1 -> accept exactly as in IDLE (back-to-back); done falls next cycle.
//   - start=0 -> go to IDLE.
//  Timing:
//   - Accepting edge = cycle 0; busy=1 in cycles 1..NBYTES.
//   - done=1 in cycle NBYTES+1 only.
//   - Throughput: one operation per NBYTES+1 cycles.
//  Result validity:
//   - sum/cout valid from done until the next accepting edge.
//   - While busy, sum holds 0 in bytes not yet computed.
//  Byte index range:
//   - Counts 0..NBYTES-1 only; never wraps while busy.
//   - For NBYTES=1, the ADD state lasts one cycle.
//  Carry:
//   - Ripples across all bytes; e.g. a=all-ones, b=1 gives sum=0, cout=1.
//  Reset mid-operation:
//   - Immediate return to the reset values; no done pulse.
//   - The partial result is discarded.
// TESTING (NBYTES=4)
//  1. Reset asserted with random a/b/start -> busy=0, done=0, sum=0, cout=0
//     throughout; stay IDLE after release with start=0.
//  2. a=0x000000FF, b=0x00000001, 1-cycle start
//     -> busy=1 for 4 cycles; done pulse 5 cycles after start edge;
//        sum=0x00000100, cout=0.
//  3. a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1.
//     a=0x80000000, b=0x80000000 -> sum=0, cout=1.
//  4. Start a=0x12345678, b=0x11111111; pulse start again 2 cycles later with
//     a=b=0xFFFFFFFF -> second start ignored; sum=0x23456789, cout=0; single done pulse.
//  5. start held high in the done cycle with a=0x00000001, b=0x00000002
//     -> accepted; next done 5 cycles later with sum=0x00000003.
//  6. rst_n pulsed low in cycle 2 of an operation
//     -> outputs 0 asynchronously; no done; next operation (a=5, b=7) gives sum=12, cout=0.

Source files
------------

// File: rtl/wide_add_seq.sv
// Multi-byte unsigned adder that reuses one 8-bit adder, one byte per cycle, LSB first.
// Operands are latched on an accepted start; sum and cout hold until the next accept.
module wide_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [8:0]      s9;

  // Next-state and datapath: a single 9-bit add on the currently selected byte.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s9      = {1'b0, a_q[{idx_q, 3'b000} +: 8]} + {1'b0, b_q[{idx_q, 3'b000} +: 8]}
              + {8'b0, carry_q};

    case (state_q)
      S_ADD: begin
        sum_d[{idx_q, 3'b000} +: 8] = s9[7:0];
        carry_d = s9[8];
        if (idx_q == IW'(NBYTES - 1)) begin
          cout_d  = s9[8];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        // Back-to-back accept from DONE behaves exactly like IDLE.
        if (start) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          cout_d  = 1'b0;
          carry_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed scenarios plus random operands against an a+b reference.
module tb_wide_add_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  wide_add_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Drive one start pulse, then observe until done (bounded). Returns observations only.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] o_sum, output logic o_cout,
                        output int o_cycles, output bit o_busy_ok);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    o_cycles = 0; o_busy_ok = 1'b1; o_sum = '0; o_cout = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c <= int'(NB) && (busy !== 1'b1 || done !== 1'b0)) o_busy_ok = 1'b0;
      if (done === 1'b1) begin
        if (busy !== 1'b0) o_busy_ok = 1'b0;
        o_cycles = c; o_sum = sum; o_cout = cout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, cout, sum} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: busy=%b done=%b sum=%h, want 0 0 0", busy, done, sum);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] vb[3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic [W:0]   exp;
    logic [W-1:0] s; logic co; int cyc; bit bok;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b0, va[i]} + {1'b0, vb[i]};
      run_op(va[i], vb[i], s, co, cyc, bok);
      n_checks++;
      if (cyc != int'(NB) + 1 || !bok) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: done at cycle %0d busy_ok=%0d, want cycle %0d busy_ok=1",
                 i, cyc, bok, NB + 1);
      end
      n_checks++;
      if (s !== exp[W-1:0] || co !== exp[W]) begin
        n_fail++;
        $display("FAIL directed_sum[%0d]: sum=%h cout=%b, want sum=%h cout=%b", i, s, co, exp[W-1:0], exp[W]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || sum !== exp[W-1:0] || cout !== exp[W]) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: done=%b sum=%h cout=%b, want done=0 sum=%h cout=%b",
                 i, done, sum, cout, exp[W-1:0], exp[W]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0; int first = 0;
    logic [W-1:0] s = '0; logic co = 1'b0;
    a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 2) begin start = 1'b1; a = '1; b = '1; end
      if (c == 3) start = 1'b0;
      if (c <= 3 && sum[W-1:16] !== '0) begin
        n_checks++; n_fail++;
        $display("FAIL partial_upper_zero: cycle %0d sum=%h, want upper bytes 0", c, sum);
      end
      if (done === 1'b1) begin
        dones++;
        if (first == 0) begin first = c; s = sum; co = cout; end
      end
    end
    n_checks++;
    if (dones != 1 || first != int'(NB) + 1) begin
      n_fail++;
      $display("FAIL ignore_start_done: %0d pulses first at %0d, want 1 pulse at %0d", dones, first, NB + 1);
    end
    n_checks++;
    if (s !== 32'h2345_6789 || co !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_sum: sum=%h cout=%b, want 23456789 0", s, co);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s; logic co; int cyc; bit bok;
    run_op(32'hDEAD_BEEF, 32'h0101_0101, s, co, cyc, bok);
    n_checks++;
    if (s !== 32'hDFAE_BFF0 || co !== 1'b0 || cyc != int'(NB) + 1) begin
      n_fail++;
      $display("FAIL b2b_first: sum=%h cout=%b cycle=%0d, want DFAEBFF0 0 %0d", s, co, cyc, NB + 1);
    end
    run_op(32'h0000_0001, 32'h0000_0002, s, co, cyc, bok);
    n_checks++;
    if (s !== 32'h0000_0003 || co !== 1'b0 || cyc != int'(NB) + 1 || !bok) begin
      n_fail++;
      $display("FAIL b2b_second: sum=%h cout=%b cycle=%0d busy_ok=%0d, want 00000003 0 %0d 1",
               s, co, cyc, bok, NB + 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s; logic co; int cyc; bit bok;
    int dones = 0;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, cout, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d done pulses busy=%b, want 0 0", dones, busy);
    end
    run_op(32'd5, 32'd7, s, co, cyc, bok);
    n_checks++;
    if (s !== 32'd12 || co !== 1'b0 || cyc != int'(NB) + 1) begin
      n_fail++;
      $display("FAIL reset_recover: sum=%h cout=%b cycle=%0d, want 0000000c 0 %0d", s, co, cyc, NB + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, s; logic co; int cyc; bit bok;
    longint unsigned exp;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 5 == 0) rb = ~ra + W'($urandom_range(0, 2));
      exp = longint'(ra) + longint'(rb);
      run_op(ra, rb, s, co, cyc, bok);
      n_checks++;
      if (s !== exp[W-1:0] || co !== exp[W] || cyc != int'(NB) + 1 || !bok) begin
        n_fail++;
        $display("FAIL random[%0d]: a=%h b=%h sum=%h cout=%b cycle=%0d busy_ok=%0d, want sum=%h cout=%b cycle=%0d",
                 i, ra, rb, s, co, cyc, bok, exp[W-1:0], exp[W], NB + 1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    start = 1'b0; a = '0; b = '0; rst_n = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
